// File: rtl/accel_pkg.sv
// Shared constants and state encoding for the systolic-array tile scheduler.
package accel_pkg;
  localparam int N         = 8;
  localparam int AW        = 8;
  localparam int FLUSH_CYC = 2 * N - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int flush_cyc(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/systolic_sched_if.sv
// Control/status bundle between the tile sequencer and its host/array.
interface systolic_sched_if #(
  parameter int N  = 8,
  parameter int AW = 8
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic [AW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          array_clr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  row_valid;
  logic [N-1:0]  col_valid;
  logic          res_wr_en;
  logic [RW-1:0] res_row;

  modport master (
    output start, k_len, abort,
    input  busy, done, array_clr, rd_en, rd_addr, row_valid, col_valid, res_wr_en, res_row
  );

  modport slave (
    input  start, k_len, abort,
    output busy, done, array_clr, rd_en, rd_addr, row_valid, col_valid, res_wr_en, res_row
  );
endinterface

// File: rtl/skew_delay.sv
// Systolic skew line: tap[i] is the input delayed by i+1 cycles.
module skew_delay #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_in,
  output logic [N-1:0] o_tap
);
  logic [N-1:0] r_tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap <= '0;
    end else if (i_clr) begin
      r_tap <= '0;
    end else begin
      r_tap <= {r_tap[N-2:0], i_in};
    end
  end

  assign o_tap = r_tap;
endmodule

// File: rtl/systolic_sched.sv
// Tile sequencer for an NxN systolic MAC array: clear, feed K operands, flush, drain rows.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_CLEAR | one cycle of partial-sum clear
//   S_FEED  | K buffer reads, addresses 0..K-1
//   S_FLUSH | 2N-1 cycles letting the skewed wavefront finish
//   S_DRAIN | N result-row captures
//   S_DONE  | one-cycle completion pulse
module systolic_sched #(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_sched_if.slave   bus
);
  import accel_pkg::*;

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FC = flush_cyc(N);
  localparam int TW = (AW > $clog2(2 * N)) ? AW : $clog2(2 * N);

  state_t        r_state;
  state_t        w_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic [AW-1:0] r_k;
  logic          w_accept;

  logic          r_busy;
  logic          r_done;
  logic          r_clr;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_res_wr_en;
  logic [RW-1:0] r_res_row;
  logic [N-1:0]  w_row_valid;
  logic [N-1:0]  w_col_valid;

  assign w_accept = bus.start && !bus.abort && (r_state == S_IDLE);

  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = r_tmr;
    if (bus.abort) begin
      w_nxt     = S_IDLE;
      w_tmr_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_nxt = (bus.k_len != '0) ? S_CLEAR : S_DONE;
          end
        end
        S_CLEAR: begin
          w_nxt     = S_FEED;
          w_tmr_nxt = TW'(r_k) - TW'(1);
        end
        S_FEED: begin
          if (r_tmr == '0) begin
            w_nxt     = S_FLUSH;
            w_tmr_nxt = TW'(FC - 1);
          end else begin
            w_tmr_nxt = r_tmr - TW'(1);
          end
        end
        S_FLUSH: begin
          if (r_tmr == '0) begin
            w_nxt     = S_DRAIN;
            w_tmr_nxt = TW'(N - 1);
          end else begin
            w_tmr_nxt = r_tmr - TW'(1);
          end
        end
        S_DRAIN: begin
          if (r_tmr == '0) begin
            w_nxt = S_DONE;
          end else begin
            w_tmr_nxt = r_tmr - TW'(1);
          end
        end
        S_DONE:  w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr_nxt;
      if (w_accept) begin
        r_k <= bus.k_len;
      end
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clr       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_res_wr_en <= 1'b0;
      r_res_row   <= '0;
    end else begin
      r_busy      <= (w_nxt != S_IDLE);
      r_done      <= (w_nxt == S_DONE);
      r_clr       <= (w_nxt == S_CLEAR);
      r_rd_en     <= (w_nxt == S_FEED);
      r_res_wr_en <= (w_nxt == S_DRAIN);
      r_rd_addr   <= (w_nxt == S_FEED && r_state == S_FEED) ? r_rd_addr + AW'(1) : '0;
      r_res_row   <= (w_nxt == S_DRAIN && r_state == S_DRAIN) ? r_res_row + RW'(1) : '0;
    end
  end

  skew_delay #(.N(N)) u_row_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.abort),
    .i_in  (r_rd_en),
    .o_tap (w_row_valid)
  );

  skew_delay #(.N(N)) u_col_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.abort),
    .i_in  (r_rd_en),
    .o_tap (w_col_valid)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.array_clr = r_clr;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.res_wr_en = r_res_wr_en;
  assign bus.res_row   = r_res_row;
  assign bus.row_valid = w_row_valid;
  assign bus.col_valid = w_col_valid;
endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched (N=8, AW=8): cycle-by-cycle output vectors against a timing model.
module tb_systolic_sched;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  systolic_sched_if #(.N(8), .AW(8)) bus ();

  systolic_sched #(.N(8), .AW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {bus.busy, bus.done, bus.array_clr, bus.rd_en, bus.rd_addr,
            bus.row_valid, bus.col_valid, bus.res_wr_en, bus.res_row};
  endfunction

  // Expected outputs n cycles after the start edge; zero after an abort at cycle ab.
  function automatic logic [31:0] model(input int n, input int k, input int ab);
    logic       busy, done, clr, rd, wr;
    logic [7:0] addr, rv;
    logic [2:0] row;
    if (n < 1 || (ab > 0 && n > ab)) return 32'h0;
    if (k == 0) return (n == 1) ? 32'hC000_0000 : 32'h0;
    busy = (n <= k + 25);
    done = (n == k + 25);
    clr  = (n == 1);
    rd   = (n >= 2) && (n <= k + 1);
    addr = rd ? 8'(n - 2) : 8'h00;
    for (int i = 0; i < 8; i++) rv[i] = (n >= 3 + i) && (n <= k + 2 + i);
    wr   = (n >= k + 17) && (n <= k + 24);
    row  = wr ? 3'(n - k - 17) : 3'h0;
    return {busy, done, clr, rd, addr, rv, rv, wr, row};
  endfunction

  task automatic run(input int k, input int ncyc, input int sp, input int ab);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = k[7:0];
    bus.abort = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.k_len = 8'hAA;
    for (int n = 1; n <= ncyc; n++) begin
      chk($sformatf("k%0d_c%0d", k, n), obs(), model(n, k, ab));
      bus.start = (n == sp);
      bus.k_len = (n == sp) ? 8'd5 : 8'hAA;
      bus.abort = (n == ab);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", obs(), 32'h0);
    rst_n = 1'b1;

    run(4, 32, -1, -1);
    run(0, 4, -1, -1);
    run(1, 30, -1, -1);

    // abort while rd_addr==2, then a fresh tile
    run(6, 12, -1, 4);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.k_len = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_over_start", obs(), 32'h0);
    run(4, 32, -1, -1);

    // start pulsed during DRAIN must be ignored
    run(3, 32, 23, -1);

    // reset in the middle of FLUSH
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      chk($sformatf("pre_rst_c%0d", n), obs(), model(n, 4, -1));
      if (n < 10) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async", obs(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(255, 283, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
